tlul_host_arb: RTL
==================

# tlul_host_arb

N-host to 1-device TL-UL arbiter that shares a single device port, such as a peripheral socket or the error responder, between several hosts. A-channel requests are granted round-robin, and each grant is locked until the device accepts the beat. The granted host index is recorded in an in-order tracking FIFO, and D-channel responses are routed back to the host at the FIFO head. The block sits upstream of a 1:N socket; the device is required to respond in order.

## Interface
- `NumHosts`, default 2: number of host ports; legal range 2..8.
- `MaxOutstanding`, default 4: tracking FIFO depth; legal range 1..16.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `tl_h_i`  in  `tlul_pkg::tl_h2d_t [NumHosts]`  host requests.
- `tl_h_o`  out  `tlul_pkg::tl_d2h_t [NumHosts]`  host responses.
- `tl_d_o`  out  `tlul_pkg::tl_h2d_t`  device request.
- `tl_d_i`  in  `tlul_pkg::tl_d2h_t`  device response.
- `unexp_rsp_o`  out  1  one-cycle pulse when the device asserts d_valid while the FIFO is empty.

## Operation
- **Outstanding count**
  - `cnt` has width `$clog2(MaxOutstanding+1)`.
  - `full` = (`cnt` == `MaxOutstanding`); `empty` = (`cnt` == 0).
- **Arbitration**
  - Candidates are hosts with a_valid.
  - The winner is the first candidate at or after `ptr`, searching in increasing index order with wrap-around.
  - `ptr` has width `$clog2(NumHosts)` and resets to 0.
- **Lock**
  - If the granted host's a_valid is high and the device a_ready is low, `lock` is set and `lock_idx` holds the winner.
  - While locked, `lock_idx` stays granted regardless of other requesters.
  - Lock clears on the accept cycle.
- **A-channel pass-through**
  - `tl_d_o` equals `tl_h_i[grant]`, with a_valid forced low when `full` or when there is no candidate.
  - When there is no candidate, `tl_d_o` fields are driven from host 0 with a_valid=0.
  - d_ready to the device is the d_ready of the head host.
- **Host a_ready**
  - `tl_h_o[i].a_ready` = (i == grant) & ~`full` & `tl_d_i.a_ready`.
  - All non-granted hosts see a_ready=0.
- **Accept** (device a_valid & a_ready)
  - Push the grant index into the FIFO.
  - Set `ptr` to grant+1, modulo `NumHosts`.
- **D-channel routing**
  - `tl_h_o[head]` receives all `tl_d_i` D fields.
  - Other hosts, and all hosts when the FIFO is empty, see d_valid=0 with data/fields copied from `tl_d_i`.
  - Device d_ready = ~`empty` & `tl_h_i[head].d_ready`.
  - Pop on device d_valid & d_ready.
- **Unexpected response**
  - Device d_valid while `empty`: d_ready=0, `unexp_rsp_o`=1 for that cycle, no routing.
- **Simultaneous push and pop**
  - `cnt` is unchanged; both pointers advance.
  - `full` is evaluated on the registered `cnt` only; a same-cycle pop does not free a slot for that cycle's push. There is no combinational D-to-A path.
- **Reset behaviour**
  - Reset (including mid-transaction) clears the FIFO, `cnt`, `ptr`, `lock` and `lock_idx` in the next cycle.
  - In-flight responses are subsequently flagged by `unexp_rsp_o`.

## Timing
- Zero-cycle A-channel latency (combinational pass-through).
- Zero-cycle D-channel latency.
- Grant takes effect in the same cycle as the request.
- `ptr` and FIFO state update on the clock edge after accept or pop.
- Output values during and immediately after reset:
  - All host a_ready=0 and all host d_valid=0.
  - Device a_valid=0 and device d_ready=0.
  - `unexp_rsp_o`=0.
- Throughput is one accepted beat per cycle while not `full`; sustained full-rate operation requires `MaxOutstanding` ≥ the device round-trip latency + 1.
- A host holding a_valid is granted within `NumHosts` accepted beats (starvation bound).

## Structure
- Reuse `tlul_pkg::tl_h2d_t` and `tlul_pkg::tl_d2h_t`; no new package types are needed.
- Sub-module `tlul_rr_arb`: combinational round-robin pick, parameterised by `N`, with inputs req and ptr and outputs grant index and valid.
- The tracking FIFO is inline: a register array of `$clog2(NumHosts)`-bit entries with wr/rd pointers and `cnt`.

## Test plan
- **Single host:**
  - Stimulus: host 1 issues Get to address 0x10; device replies one cycle later with data 0xDEADBEEF.
  - Required response: host 1 receives d_valid with 0xDEADBEEF; host 0 sees d_valid=0 throughout.
- **Contention, round robin:**
  - Stimulus: both hosts hold a_valid continuously with device a_ready=1, starting from `ptr`=0.
  - Required response: accepted sequence is 0,1,0,1 and response order matches.
- **Lock:**
  - Stimulus: host 0 is granted with device a_ready=0 for 3 cycles while host 1 raises a_valid.
  - Required response: the grant stays on host 0 and its request fields are stable at the device; host 1 is accepted on the cycle after host 0.
- **Full:**
  - Stimulus: `MaxOutstanding`=4; issue 4 accepts with no responses, then one more request.
  - Required response: device a_valid=0 and host a_ready=0. After one response pops, the 5th request is accepted on the following cycle, not the same cycle.
- **Backpressure and unexpected response:**
  - Stimulus 1: the head host holds d_ready=0 for 2 cycles.
  - Required response 1: device d_ready=0 for those 2 cycles and the FIFO does not pop.
  - Stimulus 2: device d_valid with the FIFO empty.
  - Required response 2: `unexp_rsp_o` pulses for 1 cycle and device d_ready=0.
- **Reset mid-operation:**
  - Stimulus: assert `rst_i` for 1 cycle with 2 requests outstanding.
  - Required response: `cnt`=0, `ptr`=0, all outputs at their reset values; the next host request is granted normally.

Source files
------------

// File: rtl/tlul_host_arb_pkg.sv
// rtl/tlul_host_arb_pkg.sv - helpers shared by the host arbiter files
//
// Purpose: modulo-n increment used for the round-robin pointer and the
// tracking FIFO pointers.
// Ports: none (package).
package tlul_host_arb_pkg;

  // cur + 1 wrapped to the range 0..n-1
  function automatic int unsigned next_idx(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel structures shared by hosts, devices and the arbiter
//
// Purpose: packed A/D channel bundles. tl_h2d_t travels host->device
// (A channel plus d_ready); tl_d2h_t travels device->host (D channel plus a_ready).
// Ports: none (package).
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_rr_arb.sv
// rtl/tlul_rr_arb.sv - combinational round-robin pick
//
// Purpose: returns the first requester at or after ptr, searching upward
// with wrap-around.
// Ports:
//   req   in  N      request vector
//   ptr   in  IW     highest-priority index
//   grant out IW     winning index (0 when nobody requests)
//   valid out 1      at least one requester
module tlul_rr_arb #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          valid
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    valid = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      j = (int'(ptr) + k) % int'(N);
      if (!valid && req[j]) begin
        valid = 1'b1;
        grant = IW'(j);
      end
    end
  end

endmodule

// File: rtl/tlul_host_arb.sv
// rtl/tlul_host_arb.sv - N-host to 1-device TL-UL arbiter with in-order response routing
//
// Purpose: round-robin A-channel arbitration with grant lock until accept,
// an in-order FIFO of granted host indices, and D-channel routing to the
// host at the FIFO head.
// Ports:
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   tl_h_i       in   host requests  [NumHosts]
//   tl_h_o       out  host responses [NumHosts]
//   tl_d_o       out  device request
//   tl_d_i       in   device response
//   unexp_rsp_o  out  device d_valid seen while nothing is outstanding
module tlul_host_arb
  import tlul_host_arb_pkg::*;
#(
  parameter int unsigned NumHosts       = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tlul_pkg::tl_h2d_t tl_h_i [NumHosts],
  output tlul_pkg::tl_d2h_t tl_h_o [NumHosts],
  output tlul_pkg::tl_h2d_t tl_d_o,
  input  tlul_pkg::tl_d2h_t tl_d_i,
  output logic              unexp_rsp_o
);

  localparam int unsigned IdxW = $clog2(NumHosts);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [NumHosts-1:0] req;
  logic [IdxW-1:0]     ptr, lock_idx, arb_idx, grant, head;
  logic                lock, arb_valid, grant_valid;
  logic [IdxW-1:0]     fifo_q [MaxOutstanding];
  logic [PtrW-1:0]     wr_ptr, rd_ptr;
  logic [CntW-1:0]     cnt;
  logic                full, empty, dev_a_valid, dev_d_ready, accept, pop;

  always_comb begin
    req = '0;
    for (int i = 0; i < int'(NumHosts); i++) req[i] = tl_h_i[i].a_valid;
  end

  tlul_rr_arb #(.N(NumHosts), .IW(IdxW)) u_rr_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_idx),
    .valid (arb_valid)
  );

  // full looks only at the registered count, so a pop never frees a slot
  // for a push in the same cycle and no D-to-A combinational path exists.
  assign full        = (cnt == CntW'(MaxOutstanding));
  assign empty       = (cnt == '0);
  assign grant       = lock ? lock_idx : arb_idx;
  assign grant_valid = lock | arb_valid;
  assign head        = fifo_q[rd_ptr];

  // Outputs are forced to their idle values while reset is asserted, since
  // the registered state only clears on the following edge.
  assign dev_a_valid = ~rst_i & grant_valid & tl_h_i[grant].a_valid & ~full;
  assign dev_d_ready = ~rst_i & ~empty & tl_h_i[head].d_ready;
  assign accept      = dev_a_valid & tl_d_i.a_ready;
  assign pop         = tl_d_i.d_valid & dev_d_ready;
  assign unexp_rsp_o = ~rst_i & tl_d_i.d_valid & empty;

  // With no candidate grant is 0, so the fields come from host 0.
  always_comb begin
    tl_d_o         = tl_h_i[grant];
    tl_d_o.a_valid = dev_a_valid;
    tl_d_o.d_ready = dev_d_ready;
  end

  always_comb begin
    for (int i = 0; i < int'(NumHosts); i++) begin
      tl_h_o[i]         = tl_d_i;
      tl_h_o[i].d_valid = ~rst_i & tl_d_i.d_valid & ~empty & (head == IdxW'(i));
      tl_h_o[i].a_ready = ~rst_i & grant_valid & (grant == IdxW'(i)) & ~full & tl_d_i.a_ready;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr      <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        lock   <= 1'b0;
        fifo_q[wr_ptr] <= grant;
        wr_ptr <= PtrW'(next_idx(int'(wr_ptr), MaxOutstanding));
        ptr    <= IdxW'(next_idx(int'(grant), NumHosts));
      end else if (grant_valid && tl_h_i[grant].a_valid && !tl_d_i.a_ready) begin
        lock     <= 1'b1;
        lock_idx <= grant;
      end
      if (pop) rd_ptr <= PtrW'(next_idx(int'(rd_ptr), MaxOutstanding));
      if (accept && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !accept) cnt <= cnt - 1'b1;
    end
  end

endmodule
